// File: rtl/piso_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// piso_frame_pkg : shared types and constants for the serial frame transmitter
// Rev 1.0
// ============================================================================
package piso_frame_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] b, input logic odd);
    return odd ? ~^b : ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_frame_tx_if.sv
`default_nettype none
// ============================================================================
// piso_frame_tx_if : byte handshake plus serial-line status bundle
// Rev 1.0
// ============================================================================
interface piso_frame_tx_if;
  import piso_frame_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic                 serial_out;
  logic                 busy;
  logic                 done;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_frame_tx_baud.sv
`default_nettype none
// ============================================================================
// baud_tick_gen : wrapping 0..CLKS_PER_BIT-1 counter, tick at terminal count
// Rev 1.0
// ============================================================================
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == C_TERM);
  assign o_tick = i_en && w_term;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/piso_frame_tx.sv
`default_nettype none
// ============================================================================
// piso_frame_tx : one-entry buffered byte-to-serial frame transmitter
// Rev 1.0
// ============================================================================
module piso_frame_tx
  import piso_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int LSB_FIRST    = 1
) (
  input  logic           clk,
  input  logic           reset,
  piso_frame_tx_if.slave if_bus
);
  state_t                 r_state, w_state_nxt;
  logic [DATA_BITS-1:0]   r_buf, r_shift, w_shift_nxt;
  logic                   r_buf_full, w_buf_full_nxt, r_data_ready;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic                   r_parity, w_parity_nxt;
  logic                   r_serial, w_serial_nxt;
  logic                   r_busy, r_done, w_done_nxt;
  logic                   w_push, w_pop, w_tick;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state != IDLE),
    .i_clr  (r_state == IDLE),
    .o_tick (w_tick)
  );

  assign w_push         = if_bus.data_valid && r_data_ready;
  assign w_buf_full_nxt = w_push ? 1'b1 : (w_pop ? 1'b0 : r_buf_full);

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_parity_nxt  = r_parity;
    w_pop         = 1'b0;
    w_done_nxt    = 1'b0;
    w_serial_nxt  = 1'b1;

    case (r_state)
      IDLE: begin
        if (r_buf_full) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_shift_nxt   = (LSB_FIRST != 0) ? {1'b0, r_shift[DATA_BITS-1:1]}
                                             : {r_shift[DATA_BITS-2:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_tick) begin
          w_done_nxt = 1'b1;
          // A byte queued during this frame starts immediately, no idle gap.
          if (r_buf_full) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_pop) begin
      w_shift_nxt   = r_buf;
      w_parity_nxt  = frame_parity(r_buf, PARITY_ODD != 0);
      w_bit_cnt_nxt = '0;
    end

    // Line level is registered from the next state so it changes on the state edge.
    case (w_state_nxt)
      START:   w_serial_nxt = 1'b0;
      DATA:    w_serial_nxt = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[DATA_BITS-1];
      PARITY:  w_serial_nxt = w_parity_nxt;
      default: w_serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_data_ready <= 1'b1;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_serial     <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      if (w_push) r_buf <= if_bus.data_in;
      r_buf_full   <= w_buf_full_nxt;
      r_data_ready <= !w_buf_full_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_parity     <= w_parity_nxt;
      r_serial     <= w_serial_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= w_done_nxt;
    end
  end

  assign if_bus.data_ready = r_data_ready;
  assign if_bus.serial_out = r_serial;
  assign if_bus.busy       = r_busy;
  assign if_bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_piso_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_piso_frame_tx : directed scoreboard bench for piso_frame_tx
// Rev 1.0
// ============================================================================
module tb_piso_frame_tx;
  import piso_frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_frame_tx_if bus0 ();
  piso_frame_tx_if bus1 ();
  piso_frame_tx_if bus2 ();
  piso_frame_tx_if bus3 ();

  piso_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .LSB_FIRST(1))
    u_dut0 (.clk(clk), .reset(rst), .if_bus(bus0));
  piso_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .LSB_FIRST(1))
    u_dut1 (.clk(clk), .reset(rst), .if_bus(bus1));
  piso_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .LSB_FIRST(1))
    u_dut2 (.clk(clk), .reset(rst), .if_bus(bus2));
  piso_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .LSB_FIRST(0))
    u_dut3 (.clk(clk), .reset(rst), .if_bus(bus3));

  int          checks    = 0;
  int          errors    = 0;
  int          frames_rx = 0;
  int          done_cnt  = 0;
  logic [10:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit j (j=0 start ... j=10 stop) as seen on the line.
  function automatic logic [10:0] exp_frame(input logic [7:0] b, input logic odd, input logic lsb);
    logic [10:0] f;
    logic        p;
    p    = odd;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = lsb ? b[i] : b[7-i];
      p      = p ^ b[i];
    end
    f[9]  = p;
    f[10] = 1'b1;
    return f;
  endfunction

  // Frame decoder on the default instance: samples mid-bit, compares to scoreboard.
  int          mon_c    = 0;
  bit          mon_on   = 1'b0;
  logic [10:0] mon_bits = '0;
  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else begin
      if (bus0.done === 1'b1) done_cnt++;
      if (!mon_on && bus0.serial_out === 1'b0) begin
        mon_on = 1'b1;
        mon_c  = 0;
      end
      if (mon_on) begin
        if (mon_c % 4 == 1) mon_bits[mon_c/4] = bus0.serial_out;
        if (mon_c == 43) begin
          mon_on = 1'b0;
          frames_rx++;
          chk("sb_has_entry", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) chk("frame_bits", mon_bits, sb_q.pop_front());
        end else begin
          mon_c++;
        end
      end
    end
  end

  task automatic send0(input logic [7:0] b, input bit keep);
    int t;
    t = 0;
    bus0.data_in    = b;
    bus0.data_valid = 1'b1;
    while (bus0.data_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("handshake_budget", t < 200, 1);
    sb_q.push_back(exp_frame(b, 1'b0, 1'b1));
    @(negedge clk);
    if (!keep) bus0.data_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (bus0.done !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("done_budget", t < limit, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gaps, early, t, base;
    logic [10:0] got;
    logic [10:0] f;
    logic        q1[$], q2[$], q3[$];

    bus0.data_in = '0; bus0.data_valid = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0;
    bus2.data_in = '0; bus2.data_valid = 1'b0;
    bus3.data_in = '0; bus3.data_valid = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_serial", bus0.serial_out, 1);
    chk("rst_ready",  bus0.data_ready, 1);
    chk("rst_busy",   bus0.busy, 0);
    chk("rst_done",   bus0.done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_serial", bus0.serial_out, 1);

    // Single 0xA5, cycle-exact
    send0(8'hA5, 1'b0);
    chk("a5_ready_low", bus0.data_ready, 0);
    got   = '0;
    early = 0;
    for (int k = 0; k <= 44; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("a5_busy_start", bus0.busy, 1);
        chk("a5_ready_back", bus0.data_ready, 1);
      end
      if (k < 44 && bus0.done === 1'b1) early++;
      if (k % 4 == 1) got[k/4] = bus0.serial_out;
      if (k == 44) begin
        chk("a5_done", bus0.done, 1);
        chk("a5_serial_idle", bus0.serial_out, 1);
        chk("a5_busy_drop", bus0.busy, 0);
      end
    end
    chk("a5_bits", got, {1'b1, 1'b0, 8'hA5, 1'b0});
    chk("a5_no_early_done", early, 0);
    @(negedge clk);
    chk("a5_done_one_cycle", bus0.done, 0);

    // Back-to-back with second byte pushed mid-frame
    base = done_cnt;
    send0(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    send0(8'hFF, 1'b0);
    wait_done(100);
    chk("b2b_restart_low", bus0.serial_out, 0);
    chk("b2b_busy_held", bus0.busy, 1);
    @(negedge clk);
    gaps = 0;
    t    = 0;
    while (bus0.done !== 1'b1 && t < 100) begin
      if (bus0.busy !== 1'b1) gaps++;
      @(negedge clk);
      t++;
    end
    chk("b2b_second_done", t < 100, 1);
    chk("b2b_busy_gaps", gaps, 0);
    @(negedge clk);
    chk("b2b_done_count", done_cnt - base, 2);
    chk("b2b_idle_busy", bus0.busy, 0);

    // Backpressure: three bytes with valid held high
    base = done_cnt;
    send0(8'h11, 1'b1);
    chk("bp_ready_low1", bus0.data_ready, 0);
    send0(8'h22, 1'b1);
    chk("bp_ready_low2", bus0.data_ready, 0);
    repeat (5) @(negedge clk);
    chk("bp_full_hold", bus0.data_ready, 0);
    send0(8'h33, 1'b0);
    chk("bp_ready_low3", bus0.data_ready, 0);
    t = 0;
    while (done_cnt < base + 3 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("bp_three_done", done_cnt - base, 3);
    chk("bp_sb_empty", sb_q.size(), 0);
    chk("bp_idle", bus0.busy, 0);

    // Reset during data bit 3 of 0x55
    send0(8'h55, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_busy", bus0.busy, 1);
    base = done_cnt;
    rst  = 1'b1;
    @(negedge clk);
    chk("mrst_serial", bus0.serial_out, 1);
    chk("mrst_busy",   bus0.busy, 0);
    chk("mrst_ready",  bus0.data_ready, 1);
    chk("mrst_done",   bus0.done, 0);
    @(negedge clk);
    rst = 1'b0;
    got = sb_q.pop_back();
    repeat (8) @(negedge clk);
    chk("mrst_no_done", done_cnt, base);
    send0(8'h01, 1'b0);
    wait_done(100);
    @(negedge clk);
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_frames", frames_rx, 7);

    // Parameter variants: odd parity, no parity, 1 clk/bit MSB first
    f = exp_frame(8'h00, 1'b1, 1'b1);
    for (int j = 0; j < 11; j++) repeat (4) q1.push_back(f[j]);
    repeat (4) q1.push_back(1'b1);
    f = exp_frame(8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 9; j++) repeat (4) q2.push_back(f[j]);
    repeat (8) q2.push_back(1'b1);
    f = exp_frame(8'h80, 1'b0, 1'b0);
    for (int j = 0; j < 11; j++) q3.push_back(f[j]);
    repeat (4) q3.push_back(1'b1);

    bus1.data_in = 8'h00; bus1.data_valid = 1'b1;
    bus2.data_in = 8'h00; bus2.data_valid = 1'b1;
    bus3.data_in = 8'h80; bus3.data_valid = 1'b1;
    @(negedge clk);
    bus1.data_valid = 1'b0;
    bus2.data_valid = 1'b0;
    bus3.data_valid = 1'b0;
    chk("odd_ready_low",  bus1.data_ready, 0);
    chk("nopar_ready_low", bus2.data_ready, 0);
    chk("cpb1_ready_low", bus3.data_ready, 0);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (q1.size() != 0) chk("odd_serial",   bus1.serial_out, q1.pop_front());
      if (q2.size() != 0) chk("nopar_serial", bus2.serial_out, q2.pop_front());
      if (q3.size() != 0) chk("cpb1_serial",  bus3.serial_out, q3.pop_front());
      if (k == 43) chk("odd_done_early", bus1.done, 0);
      if (k == 44) chk("odd_done", bus1.done, 1);
      if (k == 39) chk("nopar_done_early", bus2.done, 0);
      if (k == 40) chk("nopar_done", bus2.done, 1);
      if (k == 10) chk("cpb1_done_early", bus3.done, 0);
      if (k == 11) chk("cpb1_done", bus3.done, 1);
      if (k == 12) chk("cpb1_done_pulse", bus3.done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
